// File: rtl/ask_demodulator.sv
// ask_demodulator
//   Receive-side counterpart of an on-off-keyed ASK modulator. The line is
//   synchronised, its rising edges are counted over fixed windows of
//   BIT_CYCLES clocks, and one bit is decided per window. Window alignment is
//   fixed by the first edge seen after IDLE.
//
// Ports
//   clk            in   1      system clock, rising edge
//   reset_n        in   1      asynchronous active-low reset
//   en             in   1      receiver enable; low forces IDLE synchronously
//   ask_in         in   1      modulated ASK line (asynchronous to clk)
//   data_out       out  1      last decided bit, held between strobes
//   data_valid     out  1      1-cycle pulse when data_out is updated
//   carrier_detect out  1      high while an edge was seen in the last GAP_CYCLES
//   busy           out  1      high in ACTIVE state
//   edge_count     out  CNT_W  running edge count of the current window
module ask_demodulator #(
    parameter int BIT_CYCLES = 20,
    parameter int CNT_W      = 8,
    parameter int THRESH     = 3,
    parameter int IDLE_BITS  = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             ask_in,
    output logic             data_out,
    output logic             data_valid,
    output logic             carrier_detect,
    output logic             busy,
    output logic [CNT_W-1:0] edge_count
);

    localparam int ZR_W  = $clog2(IDLE_BITS + 1);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);

    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(BIT_CYCLES - 1);
    localparam logic [CNT_W:0]   THRESH_V  = (CNT_W + 1)'(THRESH);
    localparam logic [ZR_W-1:0]  ZR_MAX    = ZR_W'(IDLE_BITS);
    localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES);
    localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic             rise;
    logic [CNT_W-1:0] win_cnt;
    logic [ZR_W-1:0]  zero_run;
    logic [GAP_W-1:0] gap_cnt;
    logic [CNT_W-1:0] ec_next;
    logic [CNT_W:0]   total;
    logic             bit_one;

    assign rise = s2 & ~s3;

    always_comb begin
        ec_next = edge_count;
        if (rise && (edge_count != '1)) begin
            ec_next = edge_count + 1'b1;
        end
        // Decision includes an edge on the closing cycle itself.
        total   = {1'b0, edge_count} + {{CNT_W{1'b0}}, rise};
        bit_one = (total >= THRESH_V);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            s1             <= 1'b0;
            s2             <= 1'b0;
            s3             <= 1'b0;
            gap_cnt        <= '0;
            carrier_detect <= 1'b0;
            win_cnt        <= '0;
            edge_count     <= '0;
            zero_run       <= '0;
            data_out       <= 1'b0;
            data_valid     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            s1 <= ask_in;
            s2 <= s1;
            s3 <= s2;

            if (rise) begin
                gap_cnt <= GAP_LOAD;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            // Registered view of the next gap counter value being non-zero.
            carrier_detect <= rise | (gap_cnt > GAP_ONE);

            data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    if (en && rise) begin
                        state      <= ACTIVE;
                        busy       <= 1'b1;
                        win_cnt    <= CNT_W'(1);
                        edge_count <= CNT_W'(1);
                        zero_run   <= '0;
                    end
                end
                ACTIVE: begin
                    // The idle-timeout exit happens one cycle after the final
                    // zero strobe so that strobe is still seen while busy.
                    if (!en || (zero_run == ZR_MAX)) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        win_cnt    <= '0;
                        edge_count <= '0;
                        zero_run   <= '0;
                    end else if (win_cnt == WIN_LAST) begin
                        data_out   <= bit_one;
                        data_valid <= 1'b1;
                        win_cnt    <= '0;
                        edge_count <= '0;
                        zero_run   <= bit_one ? '0 : zero_run + 1'b1;
                    end else begin
                        win_cnt    <= win_cnt + 1'b1;
                        edge_count <= ec_next;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
